// File: rtl/cam_udp_pkg.sv
// Shared definitions for the camera-to-UDP packet buffer.
//   wr_state_t     : write-side framing FSM states
//   TX_IDLE/SENDCRC: sender state codes observed on tx_state
//   MARK_WORD_DEF  : default leading word of the frame marker
//   UDP_HDR/IP_UDP_HDR : header overheads for the constant length fields
package cam_udp_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_MARK = 2'd1,
    S_DATA = 2'd2,
    S_PAD  = 2'd3
  } wr_state_t;

  localparam logic [3:0]  TX_IDLE       = 4'd0;
  localparam logic [3:0]  TX_SENDCRC    = 4'd7;
  localparam logic [31:0] MARK_WORD_DEF = 32'hFF00FF00;
  localparam int unsigned UDP_HDR       = 8;
  localparam int unsigned IP_UDP_HDR    = 28;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   wr_en, wr_data : push (ignored when full)
//   rd_en          : pop head (ignored when empty)
//   rd_data        : head when non-empty, otherwise last popped byte
//   full, empty    : status
//   count          : registered occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic [DATA_W-1:0] last_q;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign count = cnt;

  // Head is read straight from the array; last_q keeps the output stable
  // once the final entry has been popped.
  assign rd_data = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cam_udp_pkt_buffer.sv
// Camera stream framer and packet buffer feeding the GMII UDP sender.
// Inserts an 8-byte marker at each frame start, zero-pads each frame to a
// whole number of PKT_BYTES packets and buffers bytes in a FWFT FIFO.
//   clk, rst          : GMII tx clock, synchronous active-high reset
//   cam_vsync/valid/data : camera stream (vsync rising edge = frame start)
//   tx_state          : sender state, used to advance frame_index
//   fifo_rd_en        : pop FIFO head
//   datain            : FIFO head byte
//   fifo_data_count   : occupancy, saturated at 2047
//   frame_index       : IP packet sequence number
//   tx_data_length    : constant UDP length
//   tx_total_length   : constant IP total length
//   overflow/underflow: sticky error flags
module cam_udp_pkt_buffer
  import cam_udp_pkg::*;
#(
  parameter int unsigned PKT_BYTES  = 1000,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter logic [31:0] MARK_WORD  = MARK_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_valid,
  input  logic [7:0]  cam_data,
  input  logic [3:0]  tx_state,
  input  logic        fifo_rd_en,
  output logic [7:0]  datain,
  output logic [10:0] fifo_data_count,
  output logic [10:0] frame_index,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned PW = $clog2(PKT_BYTES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_BYTES - 1);

  wr_state_t     state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [15:0]   frame_cnt;
  logic          frame_inc;
  logic [PW-1:0] pkt_cnt, pkt_cnt_nxt;
  logic          vsync_d;
  logic          vs_rise;
  logic [3:0]    tx_state_d;
  logic          wr_req;
  logic [7:0]    wr_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;

  assign vs_rise         = cam_vsync & ~vsync_d;
  assign tx_data_length  = 16'(PKT_BYTES + UDP_HDR);
  assign tx_total_length = 16'(PKT_BYTES + IP_UDP_HDR);
  assign fifo_data_count = (32'(fifo_cnt) > 32'd2047) ? 11'h7FF : 11'(fifo_cnt);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    frame_inc = 1'b0;
    wr_req    = 1'b0;
    wr_data   = '0;

    case (state)
      S_MARK: begin
        wr_req = 1'b1;
        case (idx)
          3'd0:    wr_data = MARK_WORD[31:24];
          3'd1:    wr_data = MARK_WORD[23:16];
          3'd2:    wr_data = MARK_WORD[15:8];
          3'd3:    wr_data = MARK_WORD[7:0];
          3'd4:    wr_data = frame_cnt[15:8];
          3'd5:    wr_data = frame_cnt[7:0];
          default: wr_data = 8'h00;
        endcase
      end
      S_DATA: begin
        wr_req  = cam_valid;
        wr_data = cam_data;
      end
      S_PAD: begin
        wr_req  = 1'b1;
        wr_data = 8'h00;
      end
      default: ;
    endcase

    pkt_cnt_nxt = pkt_cnt;
    if (wr_req && !fifo_full)
      pkt_cnt_nxt = (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PW'(1);

    case (state)
      S_SYNC: begin
        if (vs_rise) begin
          state_nxt = S_MARK;
          idx_nxt   = '0;
        end
      end
      S_MARK: begin
        idx_nxt = idx + 3'd1;
        if (idx == 3'd7) begin
          state_nxt = S_DATA;
          frame_inc = 1'b1;
        end
      end
      S_DATA: begin
        // Boundary test uses the count after this cycle's write, so a byte
        // landing together with vs_rise still leaves the frame packet-aligned.
        if (vs_rise) begin
          state_nxt = (pkt_cnt_nxt == '0) ? S_MARK : S_PAD;
          idx_nxt   = '0;
        end
      end
      S_PAD: begin
        if (wr_req && !fifo_full && pkt_cnt == PKT_LAST) begin
          state_nxt = S_MARK;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SYNC;
      idx         <= '0;
      frame_cnt   <= '0;
      pkt_cnt     <= '0;
      vsync_d     <= 1'b0;
      tx_state_d  <= TX_IDLE;
      frame_index <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pkt_cnt    <= pkt_cnt_nxt;
      vsync_d    <= cam_vsync;
      tx_state_d <= tx_state;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (tx_state_d == TX_SENDCRC && tx_state == TX_IDLE)
        frame_index <= frame_index + 11'd1;
      if (wr_req && fifo_full)      overflow  <= 1'b1;
      if (fifo_rd_en && fifo_empty) underflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_req),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (datain),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_cam_udp_pkt_buffer.sv
// Directed self-checking bench for cam_udp_pkt_buffer. Expected FIFO bytes
// are queued as stimulus is driven and compared as the FIFO is drained.
module tb_cam_udp_pkt_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_vsync;
  logic        cam_valid;
  logic [7:0]  cam_data;
  logic [3:0]  tx_state;
  logic        fifo_rd_en;
  logic [7:0]  datain;
  logic [10:0] fifo_data_count;
  logic [10:0] frame_index;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        overflow;
  logic        underflow;

  logic [7:0]  exp_q[$];
  logic [7:0]  last_b;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  cam_udp_pkt_buffer #(
    .PKT_BYTES  (1000),
    .FIFO_DEPTH (2048),
    .MARK_WORD  (32'hFF00FF00)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cam_vsync       (cam_vsync),
    .cam_valid       (cam_valid),
    .cam_data        (cam_data),
    .tx_state        (tx_state),
    .fifo_rd_en      (fifo_rd_en),
    .datain          (datain),
    .fifo_data_count (fifo_data_count),
    .frame_index     (frame_index),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_marker(input logic [15:0] fc);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(fc[15:8]); exp_q.push_back(fc[7:0]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
  endtask

  task automatic vs_pulse();
    cam_valid = 1'b0;
    cam_vsync = 1'b1;
    tick();
    cam_vsync = 1'b0;
  endtask

  task automatic stream(input int unsigned n, input int unsigned npush,
                        input logic [7:0] base, input logic [7:0] mul);
    for (int unsigned i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(i) * mul;
      cam_valid = 1'b1;
      cam_data  = b;
      if (i < npush) exp_q.push_back(b);
      tick();
    end
    cam_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_underrun: observed=%0h expected=none", datain);
      end else begin
        last_b = exp_q.pop_front();
        chk("fifo_byte", {24'd0, datain}, {24'd0, last_b});
      end
      fifo_rd_en = 1'b1;
      tick();
    end
    fifo_rd_en = 1'b0;
  endtask

  task automatic send_pkt(input logic do_chk, input logic [10:0] idx_exp);
    for (int unsigned s = 1; s <= 7; s++) begin
      tx_state = 4'(s);
      tick();
      if (do_chk) chk("frame_index_in_pkt", {21'd0, frame_index}, {21'd0, idx_exp});
    end
    tx_state = 4'd0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cam_vsync = 1'b0; cam_valid = 1'b0; cam_data = '0;
    tx_state = 4'd0; fifo_rd_en = 1'b0; last_b = '0;
    tick(); tick();
    chk("rst_datain",   {24'd0, datain}, 32'd0);
    chk("rst_count",    {21'd0, fifo_data_count}, 32'd0);
    chk("rst_index",    {21'd0, frame_index}, 32'd0);
    chk("rst_ovf",      {31'd0, overflow}, 32'd0);
    chk("rst_unf",      {31'd0, underflow}, 32'd0);
    chk("len_udp_rst",  {16'd0, tx_data_length}, 32'd1008);
    chk("len_ip_rst",   {16'd0, tx_total_length}, 32'd1028);
    rst = 1'b0;
    tick();

    // 1: marker + 992 bytes, count hits 1000 one cycle after the last write
    vs_pulse();
    push_marker(16'd0);
    tick();
    chk("latency_head", {24'd0, datain}, 32'hFF);
    chk("latency_cnt",  {21'd0, fifo_data_count}, 32'd1);
    repeat (7) tick();
    stream(991, 991, 8'h01, 8'h01);
    chk("cnt_999", {21'd0, fifo_data_count}, 32'd999);
    stream(1, 1, 8'(992), 8'h01);
    chk("cnt_1000", {21'd0, fifo_data_count}, 32'd1000);
    drain(1000);
    chk("cnt_empty1", {21'd0, fifo_data_count}, 32'd0);
    chk("hold_last",  {24'd0, datain}, {24'd0, last_b});

    // 2: 500 bytes, vs_rise -> 500 pad zeros, then marker frame 1
    stream(500, 500, 8'hA5, 8'h03);
    vs_pulse();
    repeat (500) exp_q.push_back(8'h00);
    push_marker(16'd1);
    repeat (508) tick();
    chk("cnt_pad", {21'd0, fifo_data_count}, 32'd1008);
    drain(1008);

    // 3: frame ends on a packet boundary -> marker immediately, no pad
    stream(992, 992, 8'h3C, 8'h05);
    vs_pulse();
    push_marker(16'd2);
    repeat (8) tick();
    chk("cnt_nopad", {21'd0, fifo_data_count}, 32'd1000);
    drain(1000);

    // 4: overflow, saturated count, first 2048 bytes intact
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    stream(3000, 2048, 8'h11, 8'h07);
    chk("cnt_sat", {21'd0, fifo_data_count}, 32'd2047);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    drain(2048);
    chk("cnt_empty4", {21'd0, fifo_data_count}, 32'd0);

    // 5: frame_index sequencing and wrap
    chk("index_0", {21'd0, frame_index}, 32'd0);
    send_pkt(1'b1, 11'd0);
    chk("index_1", {21'd0, frame_index}, 32'd1);
    send_pkt(1'b1, 11'd1);
    chk("index_2", {21'd0, frame_index}, 32'd2);
    for (int unsigned p = 0; p < 2045; p++) send_pkt(1'b0, 11'd0);
    chk("index_2047", {21'd0, frame_index}, 32'd2047);
    send_pkt(1'b1, 11'd2047);
    chk("index_wrap", {21'd0, frame_index}, 32'd0);

    // 6: underflow on empty pop, then reset while padding
    chk("unf_before", {31'd0, underflow}, 32'd0);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    chk("unf_set",   {31'd0, underflow}, 32'd1);
    chk("unf_count", {21'd0, fifo_data_count}, 32'd0);
    send_pkt(1'b0, 11'd0);
    chk("index_pre_rst", {21'd0, frame_index}, 32'd1);
    stream(3, 0, 8'h5A, 8'h00);
    vs_pulse();
    repeat (4) tick();
    chk("pad_head", {24'd0, datain}, 32'h5A);
    chk("pad_cnt",  {21'd0, fifo_data_count}, 32'd7);
    rst = 1'b1;
    tick();
    chk("mid_rst_datain", {24'd0, datain}, 32'd0);
    chk("mid_rst_count",  {21'd0, fifo_data_count}, 32'd0);
    chk("mid_rst_index",  {21'd0, frame_index}, 32'd0);
    chk("mid_rst_ovf",    {31'd0, overflow}, 32'd0);
    chk("mid_rst_unf",    {31'd0, underflow}, 32'd0);
    chk("len_udp",        {16'd0, tx_data_length}, 32'd1008);
    chk("len_ip",         {16'd0, tx_total_length}, 32'd1028);
    rst = 1'b0;
    exp_q.delete();
    stream(5, 0, 8'h77, 8'h01);
    chk("sync_discard", {21'd0, fifo_data_count}, 32'd0);
    vs_pulse();
    push_marker(16'd0);
    repeat (8) tick();
    chk("post_rst_cnt", {21'd0, fifo_data_count}, 32'd8);
    drain(8);
    chk("post_rst_empty", {21'd0, fifo_data_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
